// File: rtl/bus_arb_pkg.sv
// Shared definitions for the rq/ack bus: state encoding, default widths and
// the wait-state counter width used by both the arbiter and the responder.
package bus_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_server_regfile.sv
// Register file behind the bus responder: 2**ADDR_W entries of DATA_W bits,
// one synchronous write port and one registered read port. A write also
// echoes its data on the read port so the bus sees what was stored.
module bus_server_regfile
  import bus_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              access_en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] entry [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // One register per entry; each only loads when the access targets it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] q_reg;

      // Entry storage, cleared by reset, written on an addressed write access.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (access_en && we && (addr == ADDR_W'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign entry[gi] = q_reg;
    end
  endgenerate

  // Read port: updates only on an access and holds its value in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (access_en) begin
      rdata_reg <= we ? wdata : entry[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bus_server_responder.sv
// Server endpoint of the four-phase rq/ack bus. Captures a request in IDLE,
// counts WAIT_CYCLES wait states, performs the register access, then holds
// server_ack until the arbiter withdraws server_rq.
module bus_server_responder
  import bus_arb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              server_rq,
  output logic              server_ack,
  input  logic              server_we,
  input  logic [ADDR_W-1:0] server_addr,
  input  logic [DATA_W-1:0] server_wdata,
  output logic [DATA_W-1:0] server_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_ACK  = ST_ACK;

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ack_reg, ack_next;
  logic              busy_reg;
  logic              hold_we_reg;
  logic [ADDR_W-1:0] hold_addr_reg;
  logic [DATA_W-1:0] hold_wdata_reg;
  logic              capture;
  logic              access;

  // Next-state logic; a dropped rq during WAIT does not abort the access.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    capture    = 1'b0;
    access     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (server_rq) begin
          capture    = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          access     = 1'b1;
          ack_next   = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!server_rq) begin
          ack_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM, counter, ack and busy registers; busy follows the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      busy_reg  <= (state_next != S_IDLE);
    end
  end

  // Holding registers: bus inputs are only looked at on the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_we_reg    <= 1'b0;
      hold_addr_reg  <= '0;
      hold_wdata_reg <= '0;
    end else if (capture) begin
      hold_we_reg    <= server_we;
      hold_addr_reg  <= server_addr;
      hold_wdata_reg <= server_wdata;
    end
  end

  bus_server_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .access_en (access),
    .we        (hold_we_reg),
    .addr      (hold_addr_reg),
    .wdata     (hold_wdata_reg),
    .rdata     (server_rdata)
  );

  assign server_ack = ack_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_bus_server_responder.sv
// Directed bench for bus_server_responder: one instance with two wait states
// and one with none, driven through four-phase transactions.
module tb_bus_server_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       rq, we, ack, busy;
  logic [3:0] addr;
  logic [7:0] wdata, rdata;

  logic       rq0, we0, ack0, busy0;
  logic [3:0] addr0;
  logic [7:0] wdata0, rdata0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_server_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .server_rq    (rq),
    .server_ack   (ack),
    .server_we    (we),
    .server_addr  (addr),
    .server_wdata (wdata),
    .server_rdata (rdata),
    .busy         (busy)
  );

  bus_server_responder #(.DATA_W(8), .ADDR_W(4), .WAIT_CYCLES(0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .server_rq    (rq0),
    .server_ack   (ack0),
    .server_we    (we0),
    .server_addr  (addr0),
    .server_wdata (wdata0),
    .server_rdata (rdata0),
    .busy         (busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. scramble changes the bus
  // after capture; early_drop withdraws rq right after capture.
  task automatic txn(input bit t_we, input logic [3:0] t_addr, input logic [7:0] t_wd,
                     input logic [7:0] exp_rd, input bit scramble, input bit early_drop,
                     input string tag);
    int n;
    rq = 1'b1; we = t_we; addr = t_addr; wdata = t_wd;
    tick();
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_ack_low"}, ack, 0);
    if (early_drop) rq = 1'b0;
    n = 0;
    while (!ack && n < 20) begin
      if (scramble) begin
        addr  = addr + 4'd5;
        wdata = 8'($urandom);
      end
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_rdata"}, rdata, exp_rd);
    $display("txn %s we=%0d addr=%0d wdata=%02h rdata=%02h latency=%0d",
             tag, t_we, t_addr, t_wd, rdata, n);
    if (!early_drop) begin
      tick();
      chk({tag, "_ack_hold"}, ack, 1);
      rq = 1'b0;
    end
    tick();
    chk({tag, "_ack_fall"}, ack, 0);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    rq = 0; we = 0; addr = 0; wdata = 0;
    rq0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack0", ack0, 0);
    rst_n = 1'b1;
    tick();

    // Write then read back with two wait states.
    txn(1'b1, 4'd7, 8'hA5, 8'hA5, 1'b0, 1'b0, "wr7");
    txn(1'b0, 4'd7, 8'h00, 8'hA5, 1'b0, 1'b0, "rd7");

    // Reset asserted in the middle of a write's wait states.
    rq = 1'b1; we = 1'b1; addr = 4'd3; wdata = 8'h77;
    tick();
    tick();
    chk("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", ack, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rdata", rdata, 0);
    $display("txn rst_midwait rdata=%02h busy=%0d", rdata, busy);
    rq = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    txn(1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, "rd3_after_rst");
    txn(1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0, "rd7_after_rst");

    // Protocol violation: rq withdrawn during WAIT gives a one-cycle ack.
    txn(1'b1, 4'd2, 8'h3C, 8'h3C, 1'b0, 1'b1, "wr2_early");
    txn(1'b0, 4'd2, 8'h00, 8'h3C, 1'b0, 1'b0, "rd2");

    // Bus changes after capture must be ignored.
    txn(1'b1, 4'd6, 8'h5A, 8'h5A, 1'b1, 1'b0, "wr6_scramble");
    txn(1'b0, 4'd6, 8'h00, 8'h5A, 1'b0, 1'b0, "rd6");
    txn(1'b0, 4'd4, 8'h00, 8'h00, 1'b0, 1'b0, "rd4");
    txn(1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 1'b0, "rd5");
    txn(1'b0, 4'd2, 8'h00, 8'h3C, 1'b0, 1'b0, "rd2_again");

    // Back-to-back writes, rq re-raised as soon as ack falls.
    for (int i = 0; i < 4; i++)
      txn(1'b1, 4'(i), 8'(8'h10 + 8'(i * 17)), 8'(8'h10 + 8'(i * 17)), 1'b0, 1'b0, $sformatf("b2b_wr%0d", i));
    for (int i = 0; i < 4; i++)
      txn(1'b0, 4'(i), 8'h00, 8'(8'h10 + 8'(i * 17)), 1'b0, 1'b0, $sformatf("b2b_rd%0d", i));

    // Zero wait states: ack on the edge after capture.
    rq0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 8'h42;
    tick();
    chk("w0_wr_capture_busy", busy0, 1);
    chk("w0_wr_capture_ack", ack0, 0);
    tick();
    chk("w0_wr_ack", ack0, 1);
    chk("w0_wr_rdata", rdata0, 8'h42);
    $display("txn w0_wr0 we=1 addr=0 wdata=42 rdata=%02h", rdata0);
    rq0 = 1'b0;
    tick();
    chk("w0_wr_ack_fall", ack0, 0);
    rq0 = 1'b1; we0 = 1'b0; wdata0 = 8'h00;
    tick();
    chk("w0_rd_capture_ack", ack0, 0);
    tick();
    chk("w0_rd_ack", ack0, 1);
    chk("w0_rd_rdata", rdata0, 8'h42);
    $display("txn w0_rd0 we=0 addr=0 rdata=%02h", rdata0);
    rq0 = 1'b0;
    tick();
    chk("w0_rd_ack_fall", ack0, 0);
    chk("w0_rd_busy_fall", busy0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
